// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 64-bit RISC-V datapath over a shared memory port.
// Sequences fetch/decode/execute/memory/writeback, counts retired instructions, traps faults.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic [63:0] instret,
    output logic        fault,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_JAL    = 4'd10,
        S_FAULT  = 4'd11
    } state_t;

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tmo;
    logic [63:0]   r_instret;
    logic          r_fault;
    logic          w_mem_state;
    logic          w_tmo_hit;
    logic          w_f3_ok;
    logic          w_retire;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // mem_ready in the final allowed cycle still completes the access
    assign w_tmo_hit   = w_mem_state && !mem_ready && (r_tmo == TMO_LAST);
    assign w_f3_ok     = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                         (funct3 == 3'b110) || (funct3 == 3'b111);
    assign w_retire    = (w_next == S_FETCH) &&
                         ((r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                          (r_state == S_ALUWB) || (r_state == S_BEQ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo     <= '0;
            r_instret <= '0;
            r_fault   <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_tmo <= '0;
            end else if (w_mem_state && !mem_ready) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 64'd1;
            end
            if (w_next == S_FAULT) begin
                r_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE; else if (w_tmo_hit) w_next = S_FAULT;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = w_f3_ok ? S_EXECR : S_FAULT;
                    OP_I:              w_next = w_f3_ok ? S_EXECI : S_FAULT;
                    OP_BEQ:            w_next = (funct3 == 3'b000) ? S_BEQ : S_FAULT;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_FAULT;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB; else if (w_tmo_hit) w_next = S_FAULT;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH; else if (w_tmo_hit) w_next = S_FAULT;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BEQ:    w_next = S_FETCH;
            S_JAL:    w_next = S_ALUWB;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FAULT;
        endcase
    end

    // Gating on reset keeps every strobe low while reset is held, including mid-access.
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_control = 3'b000;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'b10;
                        result_src = 2'b10;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = 2'b10;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (opcode == OP_LOAD) ? 2'b00 : 2'b01;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR, S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                    case (funct3)
                        3'b000:  alu_control = (r_state == S_EXECR && funct7b5) ? 3'b001 : 3'b000;
                        3'b010:  alu_control = 3'b101;
                        3'b110:  alu_control = 3'b011;
                        3'b111:  alu_control = 3'b010;
                        default: alu_control = 3'b000;
                    endcase
                end
                S_ALUWB:  reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a   = 2'b10;
                    alu_control = 3'b001;
                    pc_write    = zero;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instret   = r_instret;
    assign fault     = r_fault;
    assign state_dbg = r_state;

endmodule
